// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle control sequencer.
//   state_e   - sequencer states
//   opcode_e  - instr[15:12] encodings
//   class_e   - execution class reported by mc_decode
//   ALU_*     - alu_ctrl encodings
//   FAULT_*   - fault_code encodings
//   FLAG_Z    - bit index of Z within {N,Z,C,V}
package mc_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_ORR  = 4'h3,
        OP_ADDI = 4'h4,
        OP_LDR  = 4'h5,
        OP_STR  = 4'h6,
        OP_B    = 4'h7,
        OP_BEQ  = 4'h8,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_LDR, CL_STR, CL_B, CL_BEQ, CL_HLT
    } class_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam int FLAG_Z = 2;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode decoder.
//   opcode   in  - instr[15:12]
//   alu_ctrl out - ALU operation for EXEC
//   alu_src  out - 1 selects the immediate as ALU operand B
//   reg_src  out - [0] RA1 select, [1] RA2 select
//   op_class out - execution class steering the sequencer
//   illegal  out - opcode lies outside the defined instruction set
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       alu_ctrl,
    output logic             alu_src,
    output logic [1:0]       reg_src,
    output class_e           op_class,
    output logic             illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b0;
        reg_src  = 2'b00;
        op_class = CL_ALU;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD:  ;
            OP_SUB:  alu_ctrl = ALU_SUB;
            OP_AND:  alu_ctrl = ALU_AND;
            OP_ORR:  alu_ctrl = ALU_OR;
            OP_ADDI: alu_src  = 1'b1;
            OP_LDR: begin
                alu_src  = 1'b1;
                op_class = CL_LDR;
            end
            OP_STR: begin
                // store data is read through RA2 from the rd field
                alu_src  = 1'b1;
                reg_src  = 2'b10;
                op_class = CL_STR;
            end
            OP_B: begin
                reg_src  = 2'b01;
                op_class = CL_B;
            end
            OP_BEQ: begin
                reg_src  = 2'b01;
                alu_ctrl = ALU_SUB;
                op_class = CL_BEQ;
            end
            OP_HLT:  op_class = CL_HLT;
            default: illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the 8-bit datapath.
//   clk, rst          - clock, synchronous active-high reset
//   start             - leave IDLE and begin fetching
//   instr             - instruction memory output, opcode in [15:12]
//   alu_flags         - live {N,Z,C,V} from the ALU
//   mem_ready         - data memory completes the current request
//   ir_we/pc_we/pc_src/reg_we/reg_src/alu_src/alu_ctrl/mem_req/mem_we/mem_to_reg
//                     - registered datapath controls
//   flags_q           - {N,Z,C,V} latched at the end of ALU-op EXEC
//   busy/halted/fault/fault_code - status
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | load IR, PC <= PC+2
// DECODE | classify opcode; illegal -> FAULT, HLT -> HALT
// EXEC   | ALU op / branch resolve / address compute
// MEM    | data memory request, waits for mem_ready with timeout
// WB     | register file write
// HALT   | sticky stop after HLT
// FAULT  | sticky stop after illegal opcode or memory timeout
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPC_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_src,
    output logic        alu_src,
    output logic [1:0]  alu_ctrl,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic [3:0]  flags_q,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
`ifdef MC_PERF_CNT_EN
   ,output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state;
    class_e     op_class_q;
    logic [7:0] wait_cnt;

    logic [1:0] dec_alu_ctrl;
    logic       dec_alu_src;
    logic [1:0] dec_reg_src;
    class_e     dec_class;
    logic       dec_illegal;

    // Operand fields are consumed by the datapath, not by the sequencer.
    logic unused_instr_fields;
    assign unused_instr_fields = ^instr[15-OPC_W:0];

    mc_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode   (instr[15 -: OPC_W]),
        .alu_ctrl (dec_alu_ctrl),
        .alu_src  (dec_alu_src),
        .reg_src  (dec_reg_src),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    // Outputs are registered alongside the state, so every assignment below
    // sets the controls seen during the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_class_q <= CL_ALU;
            wait_cnt   <= 8'd0;
            ir_we      <= 1'b0;
            pc_we      <= 1'b0;
            pc_src     <= 1'b0;
            reg_we     <= 1'b0;
            reg_src    <= 2'b00;
            alu_src    <= 1'b0;
            alu_ctrl   <= ALU_ADD;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_to_reg <= 1'b0;
            flags_q    <= 4'b0000;
            busy       <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            ir_we      <= 1'b0;
            pc_we      <= 1'b0;
            pc_src     <= 1'b0;
            reg_we     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_to_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        ir_we <= 1'b1;
                        pc_we <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (dec_illegal) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_ILLEGAL;
                        busy       <= 1'b0;
                    end else if (dec_class == CL_HLT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state      <= EXEC;
                        op_class_q <= dec_class;
                        alu_ctrl   <= dec_alu_ctrl;
                        alu_src    <= dec_alu_src;
                        reg_src    <= dec_reg_src;
                        // branch condition uses flags from earlier instructions
                        if (dec_class == CL_B) begin
                            pc_we  <= 1'b1;
                            pc_src <= 1'b1;
                        end else if (dec_class == CL_BEQ) begin
                            pc_we  <= flags_q[FLAG_Z];
                            pc_src <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    case (op_class_q)
                        CL_LDR, CL_STR: begin
                            state    <= MEM;
                            mem_req  <= 1'b1;
                            mem_we   <= (op_class_q == CL_STR);
                            wait_cnt <= 8'd0;
                        end
                        CL_B, CL_BEQ: begin
                            state    <= FETCH;
                            ir_we    <= 1'b1;
                            pc_we    <= 1'b1;
                            alu_ctrl <= ALU_ADD;
                            alu_src  <= 1'b0;
                            reg_src  <= 2'b00;
                        end
                        default: begin
                            state   <= WB;
                            reg_we  <= 1'b1;
                            flags_q <= alu_flags;
                        end
                    endcase
                end
                MEM: begin
                    // ready on the final allowed cycle still completes
                    if (mem_ready) begin
                        if (op_class_q == CL_LDR) begin
                            state      <= WB;
                            reg_we     <= 1'b1;
                            mem_to_reg <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            ir_we    <= 1'b1;
                            pc_we    <= 1'b1;
                            alu_ctrl <= ALU_ADD;
                            alu_src  <= 1'b0;
                            reg_src  <= 2'b00;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                        busy       <= 1'b0;
                        alu_ctrl   <= ALU_ADD;
                        alu_src    <= 1'b0;
                        reg_src    <= 2'b00;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        mem_req  <= 1'b1;
                        mem_we   <= (op_class_q == CL_STR);
                    end
                end
                WB: begin
                    state    <= FETCH;
                    ir_we    <= 1'b1;
                    pc_we    <= 1'b1;
                    alu_ctrl <= ALU_ADD;
                    alu_src  <= 1'b0;
                    reg_src  <= 2'b00;
                end
                HALT:    state <= HALT;
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic instret;
    assign instret = (state == WB)
                   || (state == EXEC && (op_class_q == CL_B || op_class_q == CL_BEQ))
                   || (state == MEM && mem_ready && op_class_q == CL_STR);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (busy)    cycle_cnt   <= cycle_cnt + 32'd1;
            if (instret) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

    localparam int TMO = 15;

    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_FETCH = 7'b1100000;
    localparam logic [6:0] E_WB    = 7'b0001000;
    localparam logic [6:0] E_WBL   = 7'b0001001;
    localparam logic [6:0] E_MR    = 7'b0000100;
    localparam logic [6:0] E_MW    = 7'b0000110;
    localparam logic [6:0] E_B     = 7'b0110000;

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_BUSY = 5'b10000;
    localparam logic [4:0] S_HALT = 5'b01000;
    localparam logic [4:0] S_ILL  = 5'b00101;
    localparam logic [4:0] S_TMO  = 5'b00110;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [15:0] instr;
    logic [3:0]  alu_flags;
    logic        ir_we, pc_we, pc_src, reg_we, alu_src, mem_req, mem_we, mem_to_reg;
    logic [1:0]  reg_src, alu_ctrl, fault_code;
    logic [3:0]  flags_q;
    logic        busy, halted, fault;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0]  en;
    logic [4:0]  st;
    logic [20:0] all_out;
    assign en      = {ir_we, pc_we, pc_src, reg_we, mem_req, mem_we, mem_to_reg};
    assign st      = {busy, halted, fault, fault_code};
    assign all_out = {en, st, alu_ctrl, alu_src, reg_src, flags_q};

    mc_sequencer #(.MEM_TIMEOUT(TMO), .OPC_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_src(reg_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
        .flags_q(flags_q), .busy(busy), .halted(halted), .fault(fault),
        .fault_code(fault_code)
`ifdef MC_PERF_CNT_EN
       ,.cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_flags = 4'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // one start pulse; returns in the first FETCH cycle
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        instr = 16'($urandom);
        do_reset();
        n_cmp++;
        if (all_out !== 21'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        tick();
        n_cmp++;
        if ({en, st} !== {E_NONE, S_IDLE}) begin
            n_bad++; $display("FAIL idle_hold: got %b want %b", {en, st}, {E_NONE, S_IDLE});
        end
    endtask

    task automatic test_add();
        logic [6:0] seq[$];
        logic [3:0] f;
        do_reset();
        instr = 16'h0298;
        f = 4'($urandom);
        alu_flags = f;
        kick();
        seq = '{E_FETCH, E_NONE, E_NONE, E_WB, E_FETCH};
        foreach (seq[i]) begin
            n_cmp++;
            if ({en, st} !== {seq[i], S_BUSY}) begin
                n_bad++; $display("FAIL add_cyc%0d: got %b want %b", i, {en, st}, {seq[i], S_BUSY});
            end
            if (i == 2) begin
                n_cmp++;
                if ({alu_ctrl, alu_src} !== 3'b000) begin
                    n_bad++; $display("FAIL add_alu: got %b want 000", {alu_ctrl, alu_src});
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (flags_q !== f) begin
                    n_bad++; $display("FAIL add_flags: got %b want %b", flags_q, f);
                end
            end
            tick();
        end
    endtask

    task automatic test_ldr_wait();
        logic [6:0] seq[$];
        do_reset();
        instr = {4'h5, 12'($urandom)};
        kick();
        seq = '{E_FETCH, E_NONE, E_NONE, E_MR, E_MR, E_MR, E_MR, E_WBL, E_FETCH};
        foreach (seq[i]) begin
            n_cmp++;
            if ({en, st} !== {seq[i], S_BUSY}) begin
                n_bad++; $display("FAIL ldr_cyc%0d: got %b want %b", i, {en, st}, {seq[i], S_BUSY});
            end
            if (i >= 2 && i <= 7) begin
                n_cmp++;
                if ({alu_ctrl, alu_src} !== 3'b001) begin
                    n_bad++; $display("FAIL ldr_alu_cyc%0d: got %b want 001", i, {alu_ctrl, alu_src});
                end
            end
            mem_ready = (i == 6);
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_beq();
        logic [6:0] seq[$];
        logic [3:0] f;
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            f = (z == 1) ? 4'b0100 : 4'b0000;
            instr = {4'h1, 12'($urandom)};
            alu_flags = f;
            kick();
            seq = '{E_FETCH, E_NONE, E_NONE, E_WB, E_FETCH, E_NONE,
                    (z == 1) ? E_B : 7'b0010000, E_FETCH};
            foreach (seq[i]) begin
                n_cmp++;
                if ({en, st} !== {seq[i], S_BUSY}) begin
                    n_bad++; $display("FAIL beq_z%0d_cyc%0d: got %b want %b", z, i, {en, st}, {seq[i], S_BUSY});
                end
                if (i == 4) begin
                    n_cmp++;
                    if (flags_q !== f) begin
                        n_bad++; $display("FAIL beq_z%0d_flags: got %b want %b", z, flags_q, f);
                    end
                    instr = {4'h8, 12'($urandom)};
                    alu_flags = ~f;   // live flags must not steer the branch
                end
                tick();
            end
        end
    endtask

    task automatic test_str_timeout();
        logic [6:0] e_exp;
        logic [4:0] s_exp;
        do_reset();
        instr = {4'h6, 12'($urandom)};
        kick();
        for (int i = 0; i < 3 + TMO + 4; i++) begin
            if (i == 0)            e_exp = E_FETCH;
            else if (i < 3)        e_exp = E_NONE;
            else if (i < 3 + TMO)  e_exp = E_MW;
            else                   e_exp = E_NONE;
            s_exp = (i < 3 + TMO) ? S_BUSY : S_TMO;
            n_cmp++;
            if ({en, st} !== {e_exp, s_exp}) begin
                n_bad++; $display("FAIL str_tmo_cyc%0d: got %b want %b", i, {en, st}, {e_exp, s_exp});
            end
            start = (i == 3 + TMO);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_illegal();
        for (int op = 9; op <= 14; op++) begin
            do_reset();
            instr = {4'(op), 12'($urandom)};
            kick();
            tick();
            tick();
            n_cmp++;
            if ({en, st} !== {E_NONE, S_ILL}) begin
                n_bad++; $display("FAIL illegal_op%0h: got %b want %b", op, {en, st}, {E_NONE, S_ILL});
            end
            start = 1'b1;
            tick(); tick();
            start = 1'b0;
            n_cmp++;
            if ({en, st} !== {E_NONE, S_ILL}) begin
                n_bad++; $display("FAIL illegal_sticky_op%0h: got %b want %b", op, {en, st}, {E_NONE, S_ILL});
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        instr = {4'hF, 12'($urandom)};
        kick();
        tick(); tick();
        n_cmp++;
        if ({en, st} !== {E_NONE, S_HALT}) begin
            n_bad++; $display("FAIL halt_enter: got %b want %b", {en, st}, {E_NONE, S_HALT});
        end
        instr = 16'h0298;
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        n_cmp++;
        if ({en, st} !== {E_NONE, S_HALT}) begin
            n_bad++; $display("FAIL halt_sticky: got %b want %b", {en, st}, {E_NONE, S_HALT});
        end
    endtask

    task automatic test_rst_mid_mem();
        do_reset();
        instr = {4'h5, 12'($urandom)};
        alu_flags = 4'hF;
        kick();
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (en !== E_MR) begin
            n_bad++; $display("FAIL rst_mem_pre: got %b want %b", en, E_MR);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (all_out !== 21'd0) begin
            n_bad++; $display("FAIL rst_mem_clear: got %h want 0", all_out);
        end
        tick();
        n_cmp++;
        if (all_out !== 21'd0) begin
            n_bad++; $display("FAIL rst_mem_idle: got %h want 0", all_out);
        end
    endtask

    // Random legal program against a per-instruction model of the expected
    // control trace, built from opcode class, memory wait and latched flags.
    task automatic test_random();
        logic [6:0]  seq[$];
        logic [3:0]  op, f, mflags;
        logic [2:0]  ealu;
        logic [15:0] ins;
        int          d, cyc, nret;
        do_reset();
        mflags = 4'h0; cyc = 0; nret = 0;
        kick();
        for (int k = 0; k < 60; k++) begin
            op  = 4'($urandom_range(0, 8));
            ins = {op, 12'($urandom)};
            d   = $urandom_range(0, 4);
            f   = 4'($urandom);
            seq = '{E_FETCH, E_NONE};
            case (op)
                4'd5: begin
                    seq.push_back(E_NONE);
                    repeat (d + 1) seq.push_back(E_MR);
                    seq.push_back(E_WBL);
                end
                4'd6: begin
                    seq.push_back(E_NONE);
                    repeat (d + 1) seq.push_back(E_MW);
                end
                4'd7:    seq.push_back(E_B);
                4'd8:    seq.push_back({1'b0, mflags[2], 1'b1, 4'b0000});
                default: begin
                    seq.push_back(E_NONE);
                    seq.push_back(E_WB);
                end
            endcase
            case (op)
                4'd0:    ealu = 3'b000;
                4'd1:    ealu = 3'b010;
                4'd2:    ealu = 3'b100;
                4'd3:    ealu = 3'b110;
                default: ealu = 3'b001;
            endcase
            instr = ins;
            alu_flags = f;
            foreach (seq[j]) begin
                n_cmp++;
                if ({en, st} !== {seq[j], S_BUSY}) begin
                    n_bad++; $display("FAIL rand_i%0d_op%0h_cyc%0d: got %b want %b", k, op, j, {en, st}, {seq[j], S_BUSY});
                end
                if (j == 2 && op <= 4'd6) begin
                    n_cmp++;
                    if ({alu_ctrl, alu_src} !== ealu) begin
                        n_bad++; $display("FAIL rand_alu_i%0d_op%0h: got %b want %b", k, op, {alu_ctrl, alu_src}, ealu);
                    end
                end
                mem_ready = (op == 4'd5 || op == 4'd6) && (j - 3 == d);
                tick();
            end
            mem_ready = 1'b0;
            if (op <= 4'd4) mflags = f;
            cyc += seq.size();
            nret++;
            n_cmp++;
            if (flags_q !== mflags) begin
                n_bad++; $display("FAIL rand_flags_i%0d: got %b want %b", k, flags_q, mflags);
            end
`ifdef MC_PERF_CNT_EN
            n_cmp++;
            if (cycle_cnt !== 32'(cyc) || instret_cnt !== 32'(nret)) begin
                n_bad++; $display("FAIL rand_perf_i%0d: got %0d/%0d want %0d/%0d", k, cycle_cnt, instret_cnt, cyc, nret);
            end
`endif
        end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        instr = 16'h0298;
        kick();
        repeat (4) tick();
        instr = 16'h7000;
        repeat (3) tick();
        instr = 16'hF000;
        repeat (2) tick();
        n_cmp++;
        if (st !== S_HALT || cycle_cnt !== 32'd9 || instret_cnt !== 32'd2) begin
            n_bad++; $display("FAIL perf_add_b_hlt: got st=%b cyc=%0d ret=%0d want st=%b cyc=9 ret=2", st, cycle_cnt, instret_cnt, S_HALT);
        end
        tick(); tick();
        n_cmp++;
        if (cycle_cnt !== 32'd9 || instret_cnt !== 32'd2) begin
            n_bad++; $display("FAIL perf_halt_frozen: got cyc=%0d ret=%0d want cyc=9 ret=2", cycle_cnt, instret_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_flags = 4'h0; instr = 16'h0;
        test_reset();
        test_add();
        test_ldr_wait();
        test_beq();
        test_str_timeout();
        test_illegal();
        test_halt();
        test_rst_mid_mem();
        test_random();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control FSM that sequences the existing 8-bit datapath: PC, instruction memory, register file, ALU and data memory.
- Replaces the single-cycle control unit so each instruction runs over several clocks.
- Adds a request/ready handshake to the data memory, a latched flag register, halt and fault handling.
- Sits between the instruction register/ALU flags and every datapath enable/select.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ready in MEM before faulting (1..255)
OPC_W, 4, opcode field width, instr[15:12]

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  leave IDLE and begin fetching
instr  input  16  instruction memory output (opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3], imm [5:0])
alu_flags  input  4  {N,Z,C,V} from the ALU, combinational
mem_ready  input  1  data memory completes the current request
ir_we  output  1  load instruction register
pc_we  output  1  load PC
pc_src  output  1  0 = PC+2, 1 = branch target
reg_we  output  1  register file write
reg_src  output  2  [0] RA1 select, [1] RA2 select (same meaning as current datapath)
alu_src  output  1  0 = rd2, 1 = imm
alu_ctrl  output  2  00 add, 01 sub, 10 and, 11 or
mem_req  output  1  data memory request
mem_we  output  1  data memory write (valid with mem_req)
mem_to_reg  output  1  writeback source: 1 = memory data
flags_q  output  4  latched {N,Z,C,V}
busy  output  1  FSM is not in IDLE/HALT/FAULT
halted  output  1  in HALT
fault  output  1  in FAULT
fault_code  output  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 LDR, 6 STR, 7 B, 8 BEQ, F HLT. All others are illegal.
- Reset: state IDLE; all outputs 0; flags_q 0; wait counter 0. Reset mid-instruction aborts it with no further enables.
- IDLE: stays until start=1, then goes to FETCH.
- FETCH (1 cycle): ir_we=1, pc_we=1, pc_src=0. Next state is DECODE.
- DECODE (1 cycle): decodes opcode. Illegal opcode → FAULT with code 01. HLT → HALT. All others → EXEC.
- EXEC (1 cycle): alu_ctrl/alu_src/reg_src driven per opcode; ADDI/LDR/STR use alu_src=1 and alu_ctrl=00.
  - ADD/SUB/AND/ORR/ADDI: flags_q <= alu_flags at the end of EXEC, then WB.
  - LDR/STR: go to MEM.
  - B: pc_we=1, pc_src=1, then FETCH.
  - BEQ: pc_we=flags_q[2], pc_src=1, then FETCH. Uses the flags latched before this instruction.
- MEM: mem_req=1; mem_we=1 for STR. ALU controls are held stable.
  - mem_ready=1 → LDR goes to WB, STR goes to FETCH.
  - Wait counter increments each cycle without ready. When the counter reaches MEM_TIMEOUT → FAULT with code 10.
  - Ready arriving on the timeout cycle wins.
- WB (1 cycle): reg_we=1; mem_to_reg=1 for LDR. ALU controls are held from EXEC. Next state is FETCH.
- Latency in cycles: ALU op 4; B/BEQ 3; STR 4+waits; LDR 5+waits.
- HALT and FAULT are sticky until rst. In both, no enables are asserted and start is ignored.
- Enables (ir_we, pc_we, reg_we, mem_req) are asserted only in the states listed above, never elsewhere.

Optional Feature:
Macro MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle while busy.
  - instret_cnt increments on each instruction completion: WB, the EXEC of B/BEQ, or the STR ready cycle.
  - Both are cleared by rst and wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state_e enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT)
  - opcode_e enum
  - alu_ctrl localparams
  - fault code localparams
  - FLAG_Z index
- One sub-module, mc_decode: combinational opcode → {alu_ctrl, alu_src, reg_src, class, illegal}.

Test Plan:
- ADD: rst, start, instr=16'h0298 (ADD r1,r2,r3) → ir_we cycle 1, DECODE, EXEC with alu_ctrl=00/alu_src=0, reg_we=1 in cycle 4, then FETCH.
- LDR with mem_ready delayed 3 cycles → mem_req high for 4 cycles, mem_we=0, WB with mem_to_reg=1, total 8 cycles.
- SUB producing alu_flags=4'b0100, then BEQ → flags_q=0100 and a pc_we/pc_src=1 pulse in BEQ EXEC. Repeat with Z=0 → no pc_we in EXEC.
- STR with mem_ready held 0 and MEM_TIMEOUT=15 → after 15 MEM cycles fault=1, fault_code=10, busy=0, no further enables.
- instr=16'hA000 → FAULT, code 01. instr=16'hF000 → halted=1, start ignored. rst mid-MEM → IDLE with all outputs 0 next cycle.
- With MC_PERF_CNT_EN: ADD then B then HLT → instret_cnt=2, cycle_cnt=9.
